restador_serial_4b: RTL and testbench

- Bit-serial subtractor: computes Y = a - b - Bi one bit per clock, LSB first, using a single difference/borrow cell and a borrow flip-flop.
- Inverse operation of the team's 4-bit ripple full adder, in the same result format: {borrow_out, difference}.
- Trades area for latency. Used where a sequential datapath has spare cycles and only one arithmetic cell fits.
- start/busy/done handshake toward the controlling FSM.

---
 rtl/restador_serial_4b_if.sv | 28 ++
 rtl/restador_serial_4b.sv | 79 +++++++
 tb/tb_restador_serial_4b.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/restador_serial_4b_if.sv
// restador_serial_4b_if: start/busy/done handshake and operand/result bus of the serial subtractor.
// RESTADOR_OVF_EN adds the signed-overflow flag ovf.
interface restador_serial_4b_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             Bi;
   logic [WIDTH:0]   Y;
   logic             busy;
   logic             done;
`ifdef RESTADOR_OVF_EN
   logic             ovf;
`endif
   modport master(
      output start, a, b, Bi,
`ifdef RESTADOR_OVF_EN
      input ovf,
`endif
      input Y, busy, done
   );
   modport slave(
      input start, a, b, Bi,
`ifdef RESTADOR_OVF_EN
      output ovf,
`endif
      output Y, busy, done
   );
endinterface

// File: rtl/restador_serial_4b.sv
// restador_serial_4b: bit-serial a - b - Bi, LSB first, one difference/borrow cell, result {borrow, diff}.
// Optional RESTADOR_OVF_EN adds a two's-complement overflow flag latched with Y.
module restador_serial_4b #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   restador_serial_4b_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-2:0] res;
   logic [CW-1:0]    cnt;
   logic             bor;
   logic             ai;
   logic             bi;
   logic             d;
   logic             bor_next;
   logic [WIDTH-1:0] res_n;
   always_comb begin
      ai       = ra[0];
      bi       = rb[0];
      d        = ai ^ bi ^ bor;
      bor_next = (~ai & bi) | (~(ai ^ bi) & bor);
      res_n    = {d, res};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         res      <= '0;
         cnt      <= '0;
         bor      <= 1'b0;
         bus.Y    <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
`ifdef RESTADOR_OVF_EN
         bus.ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               ra       <= bus.a;
               rb       <= bus.b;
               bor      <= bus.Bi;
               cnt      <= '0;
               bus.busy <= 1'b1;
               state    <= SHIFT;
            end
            SHIFT: begin
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               bor <= bor_next;
               res <= res_n[WIDTH-1:1];
               cnt <= cnt + 1'b1;
               // the MSB step: the current cell sees the operand sign bits
               if (cnt == CW'(WIDTH - 1)) begin
                  bus.Y    <= {bor_next, res_n};
                  bus.done <= 1'b1;
`ifdef RESTADOR_OVF_EN
                  bus.ovf  <= (ai ^ bi) & (d ^ ai);
`endif
                  state    <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_restador_serial_4b.sv
// tb_restador_serial_4b: randomized and directed checks of the serial subtractor against an arithmetic model.
module tb_restador_serial_4b;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   restador_serial_4b_if #(.WIDTH(W)) bus ();
   restador_serial_4b #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [W:0] model_y(input int a, input int b, input int bi);
      int dd = a - b - bi;
      return {dd < 0 ? 1'b1 : 1'b0, W'(dd)};
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      logic [W-1:0] r = W'(int'(a) - int'(b) - int'(bi));
      return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
   endfunction

   // Issues one operation; returns Y at the done pulse, cycles from acceptance to done, and whether busy stayed high.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output logic [W:0] y, output int lat, output logic busy_ok);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.Bi = bi; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.Bi = 1'($urandom);
      lat = 1;
      busy_ok = bus.busy;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (!bus.busy) busy_ok = 1'b0;
      end
      y = bus.Y;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.Bi = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.Y, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: Y=%b busy=%b done=%b, want all 0", i, bus.Y, bus.busy, bus.done);
         end
      end
   endtask

   task automatic test_basic();
      logic [W:0] y; int lat; logic bok;
      do_op(4'd9, 4'd3, 1'b0, y, lat, bok);
      checks++;
      if (y !== 5'b0_0110) begin errors++; $display("FAIL basic_y: got %b want %b", y, 5'b0_0110); end
      checks++;
      if (lat !== W + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
      checks++;
      if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy: busy dropped during operation"); end
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++; $display("FAIL basic_after_done: busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
      checks++;
      if (bus.Y !== 5'b0_0110) begin errors++; $display("FAIL basic_hold: Y=%b want %b", bus.Y, 5'b0_0110); end
   endtask

   task automatic test_wrap();
      logic [W:0] y; int lat; logic bok;
      do_op(4'd2, 4'd5, 1'b1, y, lat, bok);
      checks++;
      if (y !== 5'b1_1100) begin errors++; $display("FAIL wrap_2_5_1: got %b want %b", y, 5'b1_1100); end
      do_op(4'd0, 4'd15, 1'b1, y, lat, bok);
      checks++;
      if (y !== 5'b1_0000) begin errors++; $display("FAIL wrap_0_15_1: got %b want %b", y, 5'b1_0000); end
      do_op(4'd15, 4'd0, 1'b0, y, lat, bok);
      checks++;
      if (y !== 5'b0_1111) begin errors++; $display("FAIL wrap_15_0_0: got %b want %b", y, 5'b0_1111); end
   endtask

   task automatic test_back_to_back();
      int acc = 0, dn = 0, last = -1;
      logic pb = 1'b0;
      logic [W:0] exp_y;
      @(negedge clk);
      bus.a = 4'd15; bus.b = 4'd1; bus.Bi = 1'b0; bus.start = 1'b1;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (bus.busy && !pb) begin
            acc++;
            bus.a = (acc % 2) ? 4'd7 : 4'd15;
            bus.b = (acc % 2) ? 4'd7 : 4'd1;
         end
         if (bus.done) begin
            exp_y = (dn % 2) ? model_y(7, 7, 0) : model_y(15, 1, 0);
            checks++;
            if (bus.Y !== exp_y) begin errors++; $display("FAIL b2b_y op %0d: got %b want %b", dn, bus.Y, exp_y); end
            if (last >= 0) begin
               checks++;
               if (c - last !== W + 2) begin errors++; $display("FAIL b2b_period: got %0d want %0d", c - last, W + 2); end
            end
            last = c;
            dn++;
         end
         pb = bus.busy;
      end
      checks++;
      if (dn !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", dn); end
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [W:0] y; int lat; logic bok; logic seen = 1'b0;
      @(negedge clk);
      bus.a = 4'd8; bus.b = 4'd1; bus.Bi = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.Y, bus.busy, bus.done} !== '0) begin
         errors++; $display("FAIL reset_mid: Y=%b busy=%b done=%b want all 0", bus.Y, bus.busy, bus.done);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done: got done=1 want none"); end
      do_op(4'd8, 4'd1, 1'b0, y, lat, bok);
      checks++;
      if (y !== 5'b0_0111 || lat !== W + 1) begin
         errors++; $display("FAIL reset_mid_restart: Y=%b lat=%0d want %b lat=%0d", y, lat, 5'b0_0111, W + 1);
      end
   endtask

   task automatic test_random();
      logic [W:0] y; int lat; logic bok;
      logic [W-1:0] a, b; logic bi;
      for (int i = 0; i < 30; i++) begin
         a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
         do_op(a, b, bi, y, lat, bok);
         checks++;
         if (y !== model_y(a, b, bi) || lat !== W + 1 || bok !== 1'b1) begin
            errors++;
            $display("FAIL random %0d-%0d-%0d: Y=%b lat=%0d busy_ok=%b want Y=%b lat=%0d busy_ok=1",
                     a, b, bi, y, lat, bok, model_y(a, b, bi), W + 1);
         end
`ifdef RESTADOR_OVF_EN
         checks++;
         if (bus.ovf !== model_ovf(a, b, bi)) begin
            errors++; $display("FAIL random_ovf %0d-%0d-%0d: got %b want %b", a, b, bi, bus.ovf, model_ovf(a, b, bi));
         end
`endif
      end
   endtask

`ifdef RESTADOR_OVF_EN
   task automatic test_ovf();
      logic [W:0] y; int lat; logic bok;
      do_op(4'b0111, 4'b1000, 1'b0, y, lat, bok);
      checks++;
      if (y[W-1:0] !== 4'b1111 || bus.ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_set: diff=%b ovf=%b want 1111 1", y[W-1:0], bus.ovf);
      end
      do_op(4'd3, 4'd1, 1'b0, y, lat, bok);
      checks++;
      if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.ovf); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef RESTADOR_OVF_EN
      test_ovf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
